// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ICACHE_INDEX_WIDTH  = 6;
  localparam int ICACHE_OFFSET_WIDTH = 4;
  localparam int ICACHE_TAG_WIDTH    = 32 - ICACHE_INDEX_WIDTH - ICACHE_OFFSET_WIDTH;
  localparam int ICACHE_WORD_WIDTH   = ICACHE_OFFSET_WIDTH - 2;
  localparam int WORDS_PER_LINE      = 1 << ICACHE_WORD_WIDTH;
  localparam int NUM_LINES           = 1 << ICACHE_INDEX_WIDTH;

  // Refill sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_data_ram.sv
// Line data storage: asynchronous read (hit data in the fetch cycle),
// synchronous write (one refill beat per cycle). Built from flops /
// distributed RAM so the read path carries no clock latency.
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int WORD_WIDTH  = ICACHE_WORD_WIDTH
) (
  input  logic                   clk,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  input  logic [WORD_WIDTH-1:0]  rd_word,
  output logic [31:0]            rd_data,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic [WORD_WIDTH-1:0]  wr_word,
  input  logic [31:0]            wr_data
);

  localparam int DEPTH = 1 << (INDEX_WIDTH + WORD_WIDTH);

  logic [31:0] mem_q [DEPTH];

  assign rd_data = mem_q[{rd_idx, rd_word}];

  // Refill beat write; contents are never reset, the valid bits guard them
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[{wr_idx, wr_word}] <= wr_data;
    end
  end

endmodule

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache. Hits return in the fetch cycle;
// misses stall the core while the whole line is refilled word 0 first,
// one outstanding sram-like read at a time.
module i_cache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH  = ICACHE_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = ICACHE_OFFSET_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_inst_en,
  input  logic [31:0] cpu_inst_addr,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int TAG_W  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WORD_W = OFFSET_WIDTH - 2;
  localparam int LINES  = 1 << INDEX_WIDTH;
  localparam logic [WORD_W-1:0] LAST_BEAT = '1;

  logic [TAG_W-1:0]       req_tag;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [WORD_W-1:0]      req_word;
  logic                   unused_addr_lsbs;

  assign req_tag          = cpu_inst_addr[31 -: TAG_W];
  assign req_idx          = cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word         = cpu_inst_addr[2 +: WORD_W];
  assign unused_addr_lsbs = ^cpu_inst_addr[1:0];

  icache_state_t          state_q, state_d;
  logic [WORD_W-1:0]      cnt_q, cnt_d;
  logic [TAG_W-1:0]       line_tag_q, line_tag_d;
  logic [INDEX_WIDTH-1:0] line_idx_q, line_idx_d;
  logic                   mem_req_q, mem_req_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]       tag_arr [LINES];
  logic                   tag_we;
  logic                   ram_we;
  logic                   beat_done;
  logic                   hit;

  // Lookup runs every cycle, refill or not; the line being refilled has
  // its valid bit cleared so it can never hit half-filled.
  assign hit            = cpu_inst_en & valid_q[req_idx] & (tag_arr[req_idx] == req_tag);
  assign cpu_inst_stall = cpu_inst_en & ~hit;

  assign mem_req   = mem_req_q;
  assign mem_wr    = 1'b0;
  assign mem_size  = 2'b10;
  assign mem_wdata = 32'd0;
  assign mem_addr  = (state_q == IDLE) ? 32'd0 : {line_tag_q, line_idx_q, cnt_q, 2'b00};

  // Next-state logic for the refill sequencer and the valid-bit array
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_tag_d = line_tag_q;
    line_idx_d = line_idx_q;
    valid_d    = valid_q;
    tag_we     = 1'b0;
    ram_we     = 1'b0;
    beat_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_inst_stall) begin
          state_d          = REQ;
          cnt_d            = '0;
          line_tag_d       = req_tag;
          line_idx_d       = req_idx;
          valid_d[req_idx] = 1'b0;
        end
      end
      REQ: begin
        if (mem_addr_ok) begin
          if (mem_data_ok) beat_done = 1'b1;
          else             state_d   = WAIT;
        end
      end
      WAIT: begin
        if (mem_data_ok) beat_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (beat_done) begin
      ram_we = 1'b1;
      if (cnt_q == LAST_BEAT) begin
        valid_d[line_idx_q] = 1'b1;
        tag_we              = 1'b1;
        state_d             = IDLE;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = REQ;
      end
    end

    mem_req_d = (state_d == REQ);
  end

  // Sequencer state, latched line address and valid bits; reset drops any refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      line_tag_q <= '0;
      line_idx_q <= '0;
      mem_req_q  <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_tag_q <= line_tag_d;
      line_idx_q <= line_idx_d;
      mem_req_q  <= mem_req_d;
      valid_q    <= valid_d;
    end
  end

  // Tag written once the last beat lands; no reset needed behind valid bits
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_arr[line_idx_q] <= line_tag_q;
    end
  end

  icache_data_ram #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .WORD_WIDTH  (WORD_W)
  ) u_data_ram (
    .clk     (clk),
    .rd_idx  (req_idx),
    .rd_word (req_word),
    .rd_data (cpu_inst_rdata),
    .we      (ram_we),
    .wr_idx  (line_idx_q),
    .wr_word (cnt_q),
    .wr_data (mem_rdata)
  );

endmodule

// File: tb/tb_i_cache.sv
// Bench for i_cache: latency-configurable sram-like bridge, a line-level
// behavioural cache model checked every cycle, directed scenarios with
// literal expectations, then a randomized fetch stream.
module tb_i_cache;

  logic        clk;
  logic        rst;
  logic        cpu_inst_en;
  logic [31:0] cpu_inst_addr;
  logic [31:0] cpu_inst_rdata;
  logic        cpu_inst_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  i_cache dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_inst_en    (cpu_inst_en),
    .cpu_inst_addr  (cpu_inst_addr),
    .cpu_inst_rdata (cpu_inst_rdata),
    .cpu_inst_stall (cpu_inst_stall),
    .mem_req        (mem_req),
    .mem_wr         (mem_wr),
    .mem_size       (mem_size),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_addr_ok    (mem_addr_ok),
    .mem_data_ok    (mem_data_ok),
    .mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory contents: a fixed function of the word address
  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'hDEADBEEF;
  endfunction

  // ---------------- bridge model ----------------
  int          a_lat = 0;
  int          d_lat = 0;
  bit          spur_en = 1'b0;
  bit          br_pend = 1'b0;
  int          br_acnt = 0;
  int          br_dcnt = 0;
  logic [31:0] br_addr = 32'd0;

  initial begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'd0;
    forever begin
      @(negedge clk);
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      if (rst) begin
        br_pend = 1'b0;
        br_acnt = 0;
      end else if (br_pend) begin
        if (br_dcnt == 0) begin
          mem_data_ok = 1'b1;
          mem_rdata   = memword(br_addr);
          br_pend     = 1'b0;
        end else begin
          br_dcnt--;
        end
      end else if (mem_req) begin
        if (br_acnt < a_lat) begin
          br_acnt++;
        end else begin
          mem_addr_ok = 1'b1;
          br_acnt     = 0;
          br_addr     = mem_addr;
          if (d_lat == 0) begin
            mem_data_ok = 1'b1;
            mem_rdata   = memword(mem_addr);
          end else begin
            br_pend = 1'b1;
            br_dcnt = d_lat - 1;
          end
        end
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        mem_data_ok = 1'b1;
        mem_rdata   = $urandom;
      end
    end
  end

  // ---------------- behavioural cache model ----------------
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  bit          m_busy  = 1'b0;
  bit          m_outst = 1'b0;
  logic [31:0] m_base  = 32'd0;
  int          m_beats = 0;
  int          dok_cnt = 0;
  logic [31:0] acc_log [$];

  task automatic model_step();
    logic [21:0] t;
    logic [5:0]  ix;
    bit          exp_hit;
    bit          req_exp;
    t  = cpu_inst_addr[31:10];
    ix = cpu_inst_addr[9:4];
    check("mem_wr", 32'(mem_wr), 32'd0);
    check("mem_size", 32'(mem_size), 32'd2);
    check("mem_wdata", mem_wdata, 32'd0);
    if (rst) begin
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_stall", 32'(cpu_inst_stall), 32'(cpu_inst_en));
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_busy  = 1'b0;
      m_outst = 1'b0;
      return;
    end
    exp_hit = cpu_inst_en && m_valid[ix] && (m_tag[ix] == t);
    check("stall", 32'(cpu_inst_stall), 32'(cpu_inst_en && !exp_hit));
    if (exp_hit) check("rdata", cpu_inst_rdata, memword(cpu_inst_addr));
    req_exp = m_busy && !m_outst;
    check("mem_req", 32'(mem_req), 32'(req_exp));
    if (!m_busy) check("mem_addr_idle", mem_addr, 32'd0);
    else if (req_exp) check("mem_addr", mem_addr, m_base + 32'(4 * m_beats));
    if (mem_req && mem_addr_ok) acc_log.push_back(mem_addr);

    // advance across the coming rising edge
    if (!m_busy) begin
      if (cpu_inst_en && !exp_hit) begin
        m_busy      = 1'b1;
        m_beats     = 0;
        m_outst     = 1'b0;
        m_base      = cpu_inst_addr & ~32'hF;
        m_valid[ix] = 1'b0;
      end
    end else if ((req_exp && mem_addr_ok && mem_data_ok) || (m_outst && mem_data_ok)) begin
      dok_cnt++;
      m_beats++;
      m_outst = 1'b0;
      if (m_beats == 4) begin
        m_valid[m_base[9:4]] = 1'b1;
        m_tag[m_base[9:4]]   = m_base[31:10];
        m_busy               = 1'b0;
      end
    end else if (req_exp && mem_addr_ok) begin
      m_outst = 1'b1;
    end
  endtask

  initial begin
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic fetch(input logic [31:0] a, output int stalls, output logic [31:0] data);
    @(posedge clk);
    #1;
    cpu_inst_en   = 1'b1;
    cpu_inst_addr = a;
    stalls        = 0;
    data          = 32'd0;
    forever begin
      @(negedge clk);
      #3;
      if (!cpu_inst_stall) begin
        data = cpu_inst_rdata;
        break;
      end
      stalls++;
      if (stalls > 400) begin
        n_checks++;
        n_fail++;
        $display("FAIL fetch_timeout: addr %h still stalled after %0d cycles", a, stalls);
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    @(posedge clk);
    #1;
    cpu_inst_en = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s;
    logic [31:0] d;
    int          start;
    int          waited;
    bit          last_stall;
    logic [31:0] cold_addrs [4];
    logic [31:0] seq_data [3];
    logic [31:0] a;

    cold_addrs = '{32'h1FC00000, 32'h1FC00004, 32'h1FC00008, 32'h1FC0000C};
    seq_data   = '{32'hC16DBEEB, 32'hC16DBEE7, 32'hC16DBEE3};

    rst           = 1'b1;
    cpu_inst_en   = 1'b0;
    cpu_inst_addr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    cpu_inst_en   = 1'b1;
    cpu_inst_addr = 32'h1FC00000;
    #1;
    check("reset_stall_follows_en", 32'(cpu_inst_stall), 32'd1);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    cpu_inst_en = 1'b0;
    rst         = 1'b0;
    @(posedge clk);

    // cold miss, zero-wait bridge
    a_lat = 0;
    d_lat = 0;
    acc_log.delete();
    fetch(32'h1FC00000, s, d);
    check("cold_stall_cycles", 32'(s), 32'd5);
    check("cold_word0", d, 32'hC16DBEEF);
    check("cold_req_count", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      check("cold_req_addr", acc_log[i], cold_addrs[i]);

    // sequential hits in the filled line
    for (int i = 0; i < 3; i++) begin
      fetch(32'h1FC00004 + 32'(4 * i), s, d);
      check("seq_hit_stalls", 32'(s), 32'd0);
      check("seq_hit_data", d, seq_data[i]);
    end
    check("seq_no_new_req", 32'(acc_log.size()), 32'd4);

    // conflict on index 0
    fetch(32'h1FC00400, s, d);
    check("conflict_stalls", 32'(s), 32'd5);
    check("conflict_data", d, 32'hC16DBAEF);
    fetch(32'h1FC00000, s, d);
    check("evicted_refetch_stalls", 32'(s), 32'd5);
    check("evicted_refetch_data", d, 32'hC16DBEEF);

    // slow bridge: addr_ok after 3 cycles, data_ok 2 after that
    a_lat = 3;
    d_lat = 2;
    fetch(32'h1FC00010, s, d);
    check("slow_stalls", 32'(s), 32'd25);
    check("slow_data", d, 32'hC16DBEFF);
    fetch(32'h1FC0001C, s, d);
    check("slow_fill_word3", d, 32'hC16DBEF3);
    check("slow_fill_hit", 32'(s), 32'd0);

    // fetch disabled with arbitrary addresses
    a_lat = 0;
    d_lat = 0;
    acc_log.delete();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      cpu_inst_en   = 1'b0;
      cpu_inst_addr = {$urandom} & ~32'h3;
    end
    #1;
    check("en0_stall", 32'(cpu_inst_stall), 32'd0);
    check("en0_no_req", 32'(acc_log.size()), 32'd0);
    fetch(32'h1FC00014, s, d);
    check("en0_array_kept", 32'(s), 32'd0);
    check("en0_array_data", d, 32'hC16DBEFB);

    // reset after two of four beats
    start = dok_cnt;
    @(posedge clk);
    #1;
    cpu_inst_addr = 32'h1FC00800;
    cpu_inst_en   = 1'b1;
    waited        = 0;
    do begin
      @(negedge clk);
      #3;
      waited++;
    end while (dok_cnt < start + 2 && waited < 50);
    check("mid_rst_two_beats", 32'(dok_cnt - start), 32'd2);
    @(posedge clk);
    #1;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_req_immediate", 32'(mem_req), 32'd0);
    check("rst_partial_no_hit", 32'(cpu_inst_stall), 32'd1);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    cpu_inst_en = 1'b0;
    acc_log.delete();
    fetch(32'h1FC00800, s, d);
    check("rst_refetch_stalls", 32'(s), 32'd5);
    check("rst_refetch_data", d, 32'hC16DB6EF);
    if (acc_log.size() > 0) check("rst_refetch_word0", acc_log[0], 32'h1FC00800);
    else check("rst_refetch_req_count", 32'(acc_log.size()), 32'd4);
    fetch(32'h1FC00010, s, d);
    check("rst_cleared_other_line", 32'(s), 32'd5);

    // randomized fetch stream
    spur_en    = 1'b1;
    last_stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (!last_stall) begin
        a = {22'h07F000 + 22'($urandom_range(0, 2)),
             6'($urandom_range(0, 3) == 3 ? 63 : $urandom_range(0, 2)),
             2'($urandom_range(0, 3)), 2'b00};
        cpu_inst_en   = ($urandom_range(0, 3) != 0);
        cpu_inst_addr = a;
        if ($urandom_range(0, 63) == 0) begin
          a_lat = $urandom_range(0, 3);
          d_lat = $urandom_range(0, 3);
        end
      end
      @(negedge clk);
      #3;
      last_stall = cpu_inst_stall;
    end

    @(posedge clk);
    #1;
    cpu_inst_en = 1'b0;
    spur_en     = 1'b0;
    waited      = 0;
    while (m_busy && waited < 200) begin
      @(negedge clk);
      #3;
      waited++;
    end
    check("final_refill_drained", 32'(m_busy), 32'd0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
